pc_fetch: RTL and testbench

PC-generation and instruction-fetch stage at the front of the RISC-V pipeline. Holds the fetch PC, presents it to the shared 32-bit `adder` to compute PC+4, and selects among sequential, redirect and hold. Drives the synchronous-read instruction memory and produces the decode-stage PC and valid bit aligned with returning instruction data.

---
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch.sv | 126 ++++++++++++
 tb/tb_pc_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: adder handshake, instruction-memory request and decode-side outputs.
// The master modport is the fetch stage itself; the slave modport is its environment.
interface pc_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;
    logic [31:0] adder_in0;
    logic [31:0] adder_in1;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, pc_plus4,
        output adder_in0, adder_in1, imem_addr, imem_en,
        output pc_d, valid_d, misalign_err, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, pc_plus4,
        input  adder_in0, adder_in1, imem_addr, imem_en,
        input  pc_d, valid_d, misalign_err, fetch_count
    );
endinterface

// File: rtl/pc_fetch.sv
// PC generation and instruction fetch. Holds the fetch PC, uses the shared
// adder for PC+4, issues synchronous-read IMEM requests and tracks which PC
// the returning IMEM data belongs to at decode.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic      clk,
    input  logic      rst,
    pc_fetch_if.master bus
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_f_r;
    logic [31:0] pc_f_next_s;
    logic        imem_en_s;
    logic [31:0] pc_d_r;
    logic        valid_d_r;
    logic        misalign_r;
    logic [31:0] fetch_count_r;

    // Redirect targets are forced onto a word boundary; low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when a redirect target is not word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // State register: BOOT gives one quiet cycle after reset before fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: BOOT always advances to RUN; RUN is left only through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT:    state_next_s = RUN;
            RUN:     state_next_s = RUN;
            default: state_next_s = BOOT;
        endcase
    end

    // Fetch issue and next-PC select; redirect outranks both BOOT and stall.
    always_comb begin
        imem_en_s   = (state_r == RUN) && !bus.stall;
        pc_f_next_s = pc_f_r;
        if (bus.redirect) begin
            pc_f_next_s = word_align(bus.redirect_pc);
        end else if ((state_r == BOOT) || bus.stall) begin
            pc_f_next_s = pc_f_r;
        end else begin
            pc_f_next_s = bus.pc_plus4;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_r <= RESET_PC;
        end else begin
            pc_f_r <= pc_f_next_s;
        end
    end

    // Decode register: redirect kills the in-flight fetch, stall freezes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_d_r    <= RESET_PC;
            valid_d_r <= 1'b0;
        end else if (bus.redirect) begin
            valid_d_r <= 1'b0;
        end else if (bus.stall) begin
            valid_d_r <= valid_d_r;
        end else if (imem_en_s) begin
            pc_d_r    <= pc_f_r;
            valid_d_r <= 1'b1;
        end else begin
            valid_d_r <= 1'b0;
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else if (bus.redirect && is_misaligned(bus.redirect_pc)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    // Issued-fetch counter; killed fetches still count, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_r <= 32'd0;
        end else if (imem_en_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign bus.adder_in0    = pc_f_r;
    assign bus.adder_in1    = 32'd4;
    assign bus.imem_addr    = pc_f_r;
    assign bus.imem_en      = imem_en_s;
    assign bus.pc_d         = pc_d_r;
    assign bus.valid_d      = valid_d_r;
    assign bus.misalign_err = misalign_r;
    assign bus.fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed per-cycle vectors with hand-computed fetch
// addresses, plus a scoreboard of expected decode PCs popped by a monitor
// whenever decode accepts a valid instruction.
module tb_pc_fetch;

    localparam logic [31:0] RPC = 32'h4000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] sb[$];

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared adder model
    assign bus.pc_plus4 = bus.adder_in0 + bus.adder_in1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        en;
        logic        vld;
        logic [31:0] cnt;
        logic        mis;
        logic        push;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pc_d"},        bus.pc_d, RPC);
        check({tag, " valid_d"},     {31'd0, bus.valid_d}, 32'd0);
        check({tag, " imem_en"},     {31'd0, bus.imem_en}, 32'd0);
        check({tag, " imem_addr"},   bus.imem_addr, RPC);
        check({tag, " fetch_count"}, bus.fetch_count, 32'd0);
        check({tag, " misalign"},    {31'd0, bus.misalign_err}, 32'd0);
    endtask

    // Drive one cycle of stimulus, check the cycle's outputs, then advance.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        bus.stall       = v.stall;
        bus.redirect    = v.redir;
        bus.redirect_pc = v.rpc;
        #1;
        check({tag, " imem_addr"},   bus.imem_addr, v.addr);
        check({tag, " imem_en"},     {31'd0, bus.imem_en}, {31'd0, v.en});
        check({tag, " valid_d"},     {31'd0, bus.valid_d}, {31'd0, v.vld});
        check({tag, " fetch_count"}, bus.fetch_count, v.cnt);
        check({tag, " misalign"},    {31'd0, bus.misalign_err}, {31'd0, v.mis});
        if (v.push) sb.push_back(v.addr);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each accepted decode instruction must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && bus.valid_d && !bus.stall) begin
            if (sb.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL decode_unexpected: got pc_d 0x%08h expected no valid instruction", bus.pc_d);
            end else begin
                check("decode_pc_d", bus.pc_d, sb.pop_front());
            end
        end
    end

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        //            stall redir rpc           addr          en    vld   cnt     mis   push
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4000_0000, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h4000_0000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h4000_0004, 1'b1, 1'b1, 32'd1,  1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h4000_0008, 1'b1, 1'b1, 32'd2,  1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h4000_000C, 1'b0, 1'b1, 32'd3,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h4000_000C, 1'b0, 1'b1, 32'd3,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        32'h4000_000C, 1'b0, 1'b1, 32'd3,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h4000_000C, 1'b1, 1'b1, 32'd3,  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h4000_0010, 1'b1, 1'b1, 32'd4,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h1000_0000, 32'h4000_0014, 1'b1, 1'b1, 32'd5,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h1000_0020, 32'h1000_0000, 1'b0, 1'b0, 32'd6,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h1000_0020, 1'b1, 1'b0, 32'd6,  1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h1000_0024, 1'b1, 1'b1, 32'd7,  1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'h1000_0022, 32'h1000_0028, 1'b1, 1'b1, 32'd8,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h1000_0020, 1'b1, 1'b0, 32'd9,  1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 32'h1000_0024, 1'b1, 1'b1, 32'd10, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        32'hFFFF_FFF8, 1'b1, 1'b0, 32'd11, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        32'hFFFF_FFFC, 1'b1, 1'b1, 32'd12, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b1, 1'b1, 32'd13, 1'b1, 1'b1};

        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values("reset");
        check("adder_in1", bus.adder_in1, 32'd4);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) apply(vecs[i], i);

        // Sequential run from address 0; misaligned flag must stay set.
        for (int k = 19; k < 30; k++) begin
            v = '{1'b0, 1'b0, 32'h0, 32'(4 * (k - 18)), 1'b1, 1'b1, 32'(k - 5), 1'b1, (k != 29)};
            apply(v, k);
        end

        // Asynchronous reset between edges abandons the fetch in flight.
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) apply(vecs[i], 100 + i);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
